// File: rtl/coord_requester_if.sv
// ---------------------------------------------------------------------------
// coord_requester_if
//
// Bundles every handshake signal of the coordinate requester:
//   - req / busy                 : request side (placement logic asks for a pair)
//   - fetch / ack / rand_in      : fetch/ack link to the LFSR coordinate source
//   - out_x / out_y / out_valid / out_ready : valid/ready pair delivery
//   - err                        : one-cycle failure pulse
//
// Modports:
//   master : the requester itself (drives busy, fetch, out_*, err)
//   slave  : the environment around it (drives req, ack, rand_in, out_ready)
// ---------------------------------------------------------------------------
interface coord_requester_if #(
    parameter int WIDTH = 12
);
    logic             req;
    logic             busy;
    logic             fetch;
    logic             ack;
    logic [WIDTH-1:0] rand_in;
    logic [WIDTH-1:0] out_x;
    logic [WIDTH-1:0] out_y;
    logic             out_valid;
    logic             out_ready;
    logic             err;

    modport master (
        input  req,
        input  ack,
        input  rand_in,
        input  out_ready,
        output busy,
        output fetch,
        output out_x,
        output out_y,
        output out_valid,
        output err
    );

    modport slave (
        output req,
        output ack,
        output rand_in,
        output out_ready,
        input  busy,
        input  fetch,
        input  out_x,
        input  out_y,
        input  out_valid,
        input  err
    );
endinterface

// File: rtl/coord_requester.sv
// ---------------------------------------------------------------------------
// coord_requester
//
// Consumer end of the random-coordinate fetch/ack handshake. On a request it
// pulses `fetch` towards the LFSR source, captures the value returned with
// `ack`, and rejection-samples it into the screen window: first an X below
// MAX_X, then a Y below MAX_Y. The finished pair is offered on a valid/ready
// output. Too many rejected draws, or a source that stays silent for
// ACK_TIMEOUT cycles, ends the request with a one-cycle `err` pulse.
//
// Ports:
//   clk   : system clock, everything on the rising edge
//   reset : synchronous, active-high; returns to IDLE and clears all state
//   bus   : coord_requester_if.master (req, busy, fetch, ack, rand_in,
//           out_x, out_y, out_valid, out_ready, err)
// ---------------------------------------------------------------------------
module coord_requester #(
    parameter int WIDTH       = 12,
    parameter int MAX_X       = 640,
    parameter int MAX_Y       = 480,
    parameter int MAX_TRIES   = 16,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    coord_requester_if.master    bus
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

    // Bounds widened by one bit so that a bound equal to 2**WIDTH still fits.
    localparam logic [WIDTH:0] BOUND_X = (WIDTH + 1)'(MAX_X);
    localparam logic [WIDTH:0] BOUND_Y = (WIDTH + 1)'(MAX_Y);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_X,
        WAIT_X,
        FETCH_Y,
        WAIT_Y,
        DONE,
        ERR
    } state_t;

    state_t             state_q;
    logic [TRY_W-1:0]   tries_q;
    logic [TRY_W-1:0]   tries_d;
    logic [TO_W-1:0]    timeout_q;
    logic [TO_W-1:0]    timeout_d;
    logic [WIDTH-1:0]   xHold_q;
    logic [WIDTH-1:0]   outX_q;
    logic [WIDTH-1:0]   outY_q;
    logic               outValid_q;
    logic               fetch_q;
    logic               busy_q;
    logic               err_q;

    logic               xInRange;
    logic               yInRange;
    logic               triesSpent;
    logic               timeoutHit;

    // Unsigned window tests on the full value; a value equal to the bound
    // is outside the window.
    assign xInRange   = ({1'b0, bus.rand_in} < BOUND_X);
    assign yInRange   = ({1'b0, bus.rand_in} < BOUND_Y);

    // MAX_TRIES rejections are tolerated; the rejection that finds the
    // counter already at MAX_TRIES is the one that gives up.
    assign tries_d    = tries_q + 1'b1;
    assign triesSpent = (tries_q == TRY_W'(MAX_TRIES));

    // The timeout fires on the WAIT cycle that would bring the count of
    // silent cycles up to ACK_TIMEOUT.
    assign timeout_d  = timeout_q + 1'b1;
    assign timeoutHit = (timeout_d == TO_W'(ACK_TIMEOUT));

    // Request FSM. Every output is a register updated alongside the state,
    // so `fetch`, `busy`, `out_valid` and `err` are set on the edge that
    // enters the state they belong to. `fetch` and `err` default to low so
    // they only last one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tries_q    <= '0;
            timeout_q  <= '0;
            xHold_q    <= '0;
            outX_q     <= '0;
            outY_q     <= '0;
            outValid_q <= 1'b0;
            fetch_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            fetch_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        state_q   <= FETCH_X;
                        fetch_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        tries_q   <= '0;
                        timeout_q <= '0;
                    end
                end

                FETCH_X: begin
                    state_q   <= WAIT_X;
                    timeout_q <= '0;
                end

                WAIT_X: begin
                    if (bus.ack) begin
                        if (xInRange) begin
                            xHold_q <= bus.rand_in;
                            state_q <= FETCH_Y;
                            fetch_q <= 1'b1;
                        end else if (triesSpent) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end else begin
                            tries_q <= tries_d;
                            state_q <= FETCH_X;
                            fetch_q <= 1'b1;
                        end
                    end else if (timeoutHit) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end else begin
                        timeout_q <= timeout_d;
                    end
                end

                FETCH_Y: begin
                    state_q   <= WAIT_Y;
                    timeout_q <= '0;
                end

                // A rejected Y only redraws Y; the accepted X stays in xHold_q.
                WAIT_Y: begin
                    if (bus.ack) begin
                        if (yInRange) begin
                            outX_q     <= xHold_q;
                            outY_q     <= bus.rand_in;
                            outValid_q <= 1'b1;
                            state_q    <= DONE;
                        end else if (triesSpent) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end else begin
                            tries_q <= tries_d;
                            state_q <= FETCH_Y;
                            fetch_q <= 1'b1;
                        end
                    end else if (timeoutHit) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end else begin
                        timeout_q <= timeout_d;
                    end
                end

                // The pair is held until taken; a new req must wait for IDLE.
                DONE: begin
                    if (bus.out_ready) begin
                        state_q    <= IDLE;
                        outValid_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end

                ERR: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q    <= IDLE;
                    outValid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fetch     = fetch_q;
    assign bus.busy      = busy_q;
    assign bus.out_x     = outX_q;
    assign bus.out_y     = outY_q;
    assign bus.out_valid = outValid_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_coord_requester.sv
// ---------------------------------------------------------------------------
// tb_coord_requester
//
// Drives coord_requester through directed and randomized coordinate requests.
// The source side answers each fetch after a chosen number of extra cycles,
// and a value-sequence model predicts the outcome of each request: the number
// of fetches, whether a pair or an error results, the pair itself, and the
// edge on which the result appears.
// ---------------------------------------------------------------------------
module tb_coord_requester;

    localparam int WIDTH       = 12;
    localparam int MAX_X       = 640;
    localparam int MAX_Y       = 480;
    localparam int MAX_TRIES   = 16;
    localparam int ACK_TIMEOUT = 8;
    localparam int EDGE_BUDGET = 400;

    logic clk;
    logic reset;

    int checks;
    int errors;
    int vals[$];
    int lastX;
    int lastY;

    coord_requester_if #(.WIDTH(WIDTH)) bus ();

    coord_requester #(
        .WIDTH       (WIDTH),
        .MAX_X       (MAX_X),
        .MAX_Y       (MAX_Y),
        .MAX_TRIES   (MAX_TRIES),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=expired expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walks the value sequence the way the window rules describe: X values
    // must lie below MAX_X, then Y values below MAX_Y; every out-of-window
    // value is a rejection, and the rejection after MAX_TRIES of them ends
    // the request with an error.
    task automatic model(output int nFetch, output bit ok, output int x, output int y);
        int  rejects;
        bit  haveX;
        rejects = 0;
        haveX   = 0;
        nFetch  = 0;
        ok      = 0;
        x       = 0;
        y       = 0;
        foreach (vals[i]) begin
            nFetch++;
            if (!haveX && vals[i] < MAX_X) begin
                x     = vals[i];
                haveX = 1;
            end else if (haveX && vals[i] < MAX_Y) begin
                y  = vals[i];
                ok = 1;
                return;
            end else begin
                rejects++;
                if (rejects > MAX_TRIES) return;
            end
        end
    endtask

    function automatic int randValue();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 4095));
            1:       return int'($urandom_range(0, 479));
            2:       return int'($urandom_range(470, 650));
            default: return int'($urandom_range(4080, 4095));
        endcase
    endfunction

    // One complete request: pulse req, act as the source (ack `delay` extra
    // cycles after each fetch, or never when noAck is set), then either hold
    // the pair in DONE for holdCycles before taking it, or follow the error.
    task automatic applyStimulus(input int delay, input bit noAck, input int holdCycles);
        int  expFetch;
        bit  expOk;
        int  expX;
        int  expY;
        int  expEdges;
        int  fetchCount;
        int  valIdx;
        int  countdown;
        int  edgeNo;
        bit  finished;

        model(expFetch, expOk, expX, expY);
        if (noAck) begin
            expOk    = 0;
            expFetch = 1;
            expEdges = 1 + ACK_TIMEOUT;
        end else begin
            expEdges = expFetch * (2 + delay);
        end

        fetchCount = 0;
        valIdx     = 0;
        countdown  = 0;
        finished   = 0;

        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        edgeNo  = 0;
        checkOutput("busy_after_req", {31'b0, bus.busy}, 32'd1);
        checkOutput("fetch_after_req", {31'b0, bus.fetch}, 32'd1);

        while (!finished && edgeNo < EDGE_BUDGET) begin
            if (bus.out_valid === 1'b1 || bus.err === 1'b1) begin
                finished = 1;
            end else begin
                bus.ack     = 1'b0;
                bus.rand_in = WIDTH'($urandom);
                if (countdown > 0) begin
                    countdown--;
                    if (countdown == 0 && valIdx < vals.size()) begin
                        bus.ack     = 1'b1;
                        bus.rand_in = WIDTH'(vals[valIdx]);
                        valIdx++;
                    end
                end
                if (bus.fetch === 1'b1) begin
                    fetchCount++;
                    if (!noAck) countdown = delay + 1;
                end
                tick();
                edgeNo++;
            end
        end
        bus.ack = 1'b0;

        checkOutput("request_finished", {31'b0, finished}, 32'd1);
        checkOutput("fetch_count", fetchCount, expFetch);
        checkOutput("result_edge", edgeNo, expEdges);
        checkOutput("out_valid_result", {31'b0, bus.out_valid}, {31'b0, expOk});
        checkOutput("err_result", {31'b0, bus.err}, {31'b0, !expOk});

        if (expOk) begin
            checkOutput("out_x", bus.out_x, expX);
            checkOutput("out_y", bus.out_y, expY);
            for (int h = 0; h < holdCycles; h++) begin
                bus.req       = 1'($urandom_range(0, 1));
                bus.out_ready = 1'b0;
                tick();
                checkOutput("hold_valid", {31'b0, bus.out_valid}, 32'd1);
                checkOutput("hold_x", bus.out_x, expX);
                checkOutput("hold_y", bus.out_y, expY);
                checkOutput("hold_no_fetch", {31'b0, bus.fetch}, 32'd0);
            end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            bus.req       = 1'b0;
            checkOutput("valid_cleared", {31'b0, bus.out_valid}, 32'd0);
            checkOutput("busy_idle", {31'b0, bus.busy}, 32'd0);
            tick();
            checkOutput("idle_no_fetch", {31'b0, bus.fetch}, 32'd0);
            lastX = expX;
            lastY = expY;
        end else begin
            checkOutput("err_keeps_x", bus.out_x, lastX);
            checkOutput("err_keeps_y", bus.out_y, lastY);
            tick();
            checkOutput("err_one_cycle", {31'b0, bus.err}, 32'd0);
            checkOutput("busy_after_err", {31'b0, bus.busy}, 32'd0);
            checkOutput("valid_after_err", {31'b0, bus.out_valid}, 32'd0);
        end
    endtask

    initial begin
        int delay;
        checks        = 0;
        errors        = 0;
        lastX         = 0;
        lastY         = 0;
        reset         = 1'b1;
        bus.req       = 1'b0;
        bus.ack       = 1'b0;
        bus.rand_in   = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state.
        checkOutput("reset_busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("reset_fetch", {31'b0, bus.fetch}, 32'd0);
        checkOutput("reset_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("reset_err", {31'b0, bus.err}, 32'd0);
        checkOutput("reset_x", bus.out_x, 32'd0);
        checkOutput("reset_y", bus.out_y, 32'd0);

        // Reset while waiting for X, with the ack turning up a cycle late.
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        tick();
        checkOutput("midwait_busy", {31'b0, bus.busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset       = 1'b0;
        bus.ack     = 1'b1;
        bus.rand_in = 12'h100;
        tick();
        bus.ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("rst_busy", {31'b0, bus.busy}, 32'd0);
            checkOutput("rst_valid", {31'b0, bus.out_valid}, 32'd0);
            checkOutput("rst_err", {31'b0, bus.err}, 32'd0);
            checkOutput("rst_fetch", {31'b0, bus.fetch}, 32'd0);
            tick();
        end

        // Both values accepted first time.
        vals = '{12'h123, 12'h0A5};
        applyStimulus(0, 0, 3);

        // Rejections including values equal to the bounds; long hold in DONE.
        vals = '{12'hFFF, 12'h280, 12'h27F, 12'h1E0, 12'h1DF};
        applyStimulus(0, 0, 20);

        // Source never lands in the window: retries run out.
        vals.delete();
        for (int i = 0; i < 20; i++) vals.push_back(12'hFFF);
        applyStimulus(0, 0, 0);

        // Source never answers.
        applyStimulus(0, 1, 0);

        // Exactly MAX_TRIES rejections, then success on the largest in-window values.
        vals.delete();
        for (int i = 0; i < MAX_TRIES; i++) vals.push_back(12'hFFF);
        vals.push_back(12'h27F);
        vals.push_back(12'h1DF);
        applyStimulus(1, 0, 2);

        // Ack arriving on the last cycle before the timeout would fire.
        vals = '{12'h000, 12'h000};
        applyStimulus(ACK_TIMEOUT - 1, 0, 1);

        // Randomized requests.
        for (int r = 0; r < 20; r++) begin
            vals.delete();
            for (int i = 0; i < 20; i++) vals.push_back(randValue());
            delay = int'($urandom_range(0, ACK_TIMEOUT - 1));
            applyStimulus(delay, 0, int'($urandom_range(0, 4)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
